// File: rtl/la_dump_receiver_pkg.sv
// Shared definitions for the logic-analyzer dump receiver.
//   rx_state_e          : byte-receiver FSM encodings
//   err_flags_t         : sticky error flag bundle
//   CLKS_PER_BIT_115200 : default divider for 12 MHz / 115200 baud
package la_dump_receiver_pkg;

    localparam int CLKS_PER_BIT_115200 = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic frame;
        logic overrun;
        logic timeout;
    } err_flags_t;

endpackage

// File: rtl/la_dump_receiver_rx_byte.sv
// uart_rx_byte: 8N1 byte deserialiser.
//   clk, rst        : clock, synchronous active-high reset
//   rx              : asynchronous serial input, idles high
//   byte_data       : received byte, valid with byte_strobe
//   byte_strobe     : one-cycle pulse, stop bit sampled high
//   frame_err_pulse : one-cycle pulse, stop bit sampled low
//   idle            : FSM is in IDLE
module uart_rx_byte
    import la_dump_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err_pulse,
    output logic       idle
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_s;
    logic [1:0]    warm_pipe;   // marks when rx_s carries a real sample
    logic          seen_high;
    rx_state_e     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            warm_pipe <= '0;
            seen_high <= 1'b0;
            state     <= ST_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            warm_pipe <= {warm_pipe[0], 1'b1};
            // The synchroniser reset value of 1 must not count as a real
            // idle line, otherwise a stuck-low input would produce bytes.
            if (warm_pipe[1] && rx_s)
                seen_high <= 1'b1;
            state     <= state_n;
            timer     <= timer_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
        end
    end

    always_comb begin
        state_n         = state;
        timer_n         = timer + 1'b1;
        bit_cnt_n       = bit_cnt;
        shreg_n         = shreg;
        byte_strobe     = 1'b0;
        frame_err_pulse = 1'b0;
        unique case (state)
            ST_IDLE: begin
                timer_n = '0;
                if (!rx_s && seen_high)
                    state_n = ST_START;
            end
            ST_START: begin
                if (timer == T_HALF) begin
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer == T_FULL) begin
                    timer_n   = '0;
                    shreg_n   = {rx_s, shreg[7:1]};   // LSB first
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Return to IDLE at the mid-stop sample so a back-to-back
                // start bit is not missed.
                if (timer == T_FULL) begin
                    timer_n = '0;
                    state_n = ST_IDLE;
                    if (rx_s) byte_strobe     = 1'b1;
                    else      frame_err_pulse = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign byte_data = shreg;
    assign idle      = (state == ST_IDLE);

endmodule

// File: rtl/la_dump_receiver.sv
// la_dump_receiver: reassembles UART bytes from the logic analyzer into
// SAMPLE_BYTES-wide words (first byte in the MSBs) on a valid/ready port.
//   clk, rst    : clock, synchronous active-high reset
//   rx          : serial input from the analyzer's transmit line
//   word_data   : assembled word; word_valid/word_ready handshake
//   busy        : receiving a byte or holding a partial word
//   frame_err, overrun_err, timeout_err : sticky flags, cleared by clr_err
module la_dump_receiver
    import la_dump_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int SAMPLE_BYTES = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [8*SAMPLE_BYTES-1:0] word_data,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic                      timeout_err,
    input  logic                      clr_err
);

    localparam int W        = 8 * SAMPLE_BYTES;
    localparam int IW       = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW       = $clog2(TO_LIMIT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_BYTES - 1);

    logic [7:0]    byte_data;
    logic          byte_strobe, frame_err_pulse, rx_idle;
    logic [IW-1:0] byte_idx;
    logic [W-1:0]  asm_buf, asm_next;
    logic [CW-1:0] to_cnt;
    logic          word_done, timeout_hit;
    err_flags_t    errs, err_set;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .byte_data       (byte_data),
        .byte_strobe     (byte_strobe),
        .frame_err_pulse (frame_err_pulse),
        .idle            (rx_idle)
    );

    // Shift-left assembly leaves the first byte of the word in the MSBs.
    assign asm_next    = (asm_buf << 8) | W'(byte_data);
    assign word_done   = byte_strobe && (byte_idx == LAST_IDX);
    assign timeout_hit = rx_idle && (byte_idx != '0) && (to_cnt == CW'(TO_LIMIT - 1));

    always_comb begin
        err_set         = '0;
        err_set.frame   = frame_err_pulse;
        err_set.overrun = word_done && word_valid && !word_ready;
        err_set.timeout = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            asm_buf    <= '0;
            to_cnt     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            errs       <= '0;
        end else begin
            // Inter-byte idle counter; any start bit leaves IDLE and clears it.
            if (rx_idle && (byte_idx != '0) && !timeout_hit)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;

            if (frame_err_pulse || timeout_hit) begin
                byte_idx <= '0;
            end else if (byte_strobe) begin
                asm_buf  <= asm_next;
                byte_idx <= word_done ? '0 : byte_idx + 1'b1;
            end

            // A completing word reloads even in the consume cycle; an
            // unconsumed word is kept and the new one dropped (overrun).
            if (word_done && !(word_valid && !word_ready)) begin
                word_data  <= asm_next;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // Set beats clear when both happen in one cycle.
            errs <= (errs & ~{3{clr_err}}) | err_set;
        end
    end

    assign busy        = !rx_idle || (byte_idx != '0);
    assign frame_err   = errs.frame;
    assign overrun_err = errs.overrun;
    assign timeout_err = errs.timeout;

endmodule

// File: tb/tb_la_dump_receiver.sv
// Directed bench for la_dump_receiver at CLKS_PER_BIT=4, SAMPLE_BYTES=2.
module tb_la_dump_receiver;

    localparam int CPB = 4;
    localparam int SB  = 2;
    localparam int TOB = 20;

    logic          clk = 1'b0;
    logic          rst, rx, word_ready, clr_err;
    logic [15:0]   word_data;
    logic          word_valid, busy, frame_err, overrun_err, timeout_err;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [15:0]   got_q[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[5];

    la_dump_receiver #(.CLKS_PER_BIT(CPB), .SAMPLE_BYTES(SB), .TIMEOUT_BITS(TOB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; capture consumed words just after that.
    always @(negedge clk) begin
        #1;
        if (word_valid && word_ready)
            got_q.push_back(word_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        idle(4);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        idle(1);
    endtask

    task automatic chk_words(input string nm, input logic [15:0] exp);
        logic [15:0] w;
        w = 'x;
        if (got_q.size() > 0) w = got_q[0];
        chk({nm, "_count"}, got_q.size(), 1);
        chk({nm, "_data"}, {16'h0, w}, {16'h0, exp});
    endtask

    initial begin
        tbl[0] = '{8'hAA, 8'h55, 16'hAA55};
        tbl[1] = '{8'h12, 8'h34, 16'h1234};
        tbl[2] = '{8'h00, 8'hFF, 16'h00FF};
        tbl[3] = '{8'hFF, 8'h00, 16'hFF00};
        tbl[4] = '{8'h80, 8'h01, 16'h8001};

        rst = 1'b1; rx = 1'b0; word_ready = 1'b1; clr_err = 1'b0;
        @(negedge clk);
        idle(3);
        chk("reset_outputs", {word_data, word_valid, busy, frame_err, overrun_err, timeout_err}, 0);

        // Stuck-low line from reset must not start a byte.
        rst = 1'b0;
        idle(60);
        chk("stuck_low_busy", {busy, frame_err}, 0);
        chk("stuck_low_words", got_q.size(), 0);
        rx = 1'b1;
        idle(4);

        for (int k = 0; k < 5; k++) begin
            got_q.delete();
            send_byte(tbl[k].b0, 1'b1);
            send_byte(tbl[k].b1, 1'b1);
            idle(6);
            chk_words($sformatf("vec%0d", k), tbl[k].exp);
            chk($sformatf("vec%0d_flags", k), {word_valid, busy, frame_err, overrun_err, timeout_err}, 0);
        end

        // Frame error discards the byte; following pair forms the word.
        got_q.delete();
        send_byte(8'h3C, 1'b0);
        idle(4);
        chk("frame_err_set", frame_err, 1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(6);
        chk_words("frame", 16'h1234);
        pulse_clr();
        chk("frame_err_clr", frame_err, 0);

        // Overrun: second word dropped, first kept.
        got_q.delete();
        word_ready = 1'b0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(6);
        chk("ovr_hold", {word_data, word_valid, overrun_err}, {16'h0102, 1'b1, 1'b1});
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        idle(2);
        chk("ovr_valid_drop", word_valid, 0);
        chk_words("ovr", 16'h0102);
        pulse_clr();
        chk("ovr_clr", overrun_err, 0);
        word_ready = 1'b1;

        // Timeout discards the lone 0xDE (82 idle cycles incl. send tail).
        got_q.delete();
        send_byte(8'hDE, 1'b1);
        idle(TOB * CPB + 2 - 4);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(6);
        chk("timeout_set", timeout_err, 1);
        chk_words("timeout", 16'hBEEF);
        pulse_clr();

        // One-cycle glitch: no byte, no flag.
        got_q.delete();
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(20);
        chk("glitch_state", {busy, frame_err, overrun_err, timeout_err}, 0);
        chk("glitch_words", got_q.size(), 0);

        // Reset mid-byte with a held word and a partial word pending.
        word_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            idle(CPB);
        end
        rx = 1'b0;                       // bit 3 of 0x77
        idle(2);
        chk("pre_rst_held", {word_data, word_valid, busy}, {16'h1122, 1'b1, 1'b1});
        rst = 1'b1;
        rx = 1'b1;
        idle(3);
        chk("rst_mid_outputs", {word_data, word_valid, busy, frame_err, overrun_err, timeout_err}, 0);
        rst = 1'b0;
        word_ready = 1'b1;
        idle(4);
        got_q.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(6);
        chk_words("after_rst", 16'h00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
